attosoc_timer: RTL and testbench
================================

# attosoc_timer

Memory-mapped 32-bit down-counting timer with interrupt output for the ECP5 PicoRV32 SoC. It sits on the CPU's iomem bus (`mem_valid`/`mem_ready` handshake) next to the LED register and UART. It drives one bit of the CPU `irq` vector, replacing the constant-zero tie-off. Software programs a reload value, starts the counter, and receives a level interrupt on expiry, in one-shot or auto-reload mode.

## Interface
- `BASE_ADDR`, default 32'h0300_0000: window base; selection uses `iomem_addr[31:8] == BASE_ADDR[31:8]`.
- `clk`  in  1: system clock.
- `resetn`  in  1: asynchronous, active-low reset.
- `iomem_valid`  in  1: CPU bus request (already gated to io space).
- `iomem_ready`  out  1: transfer complete, registered.
- `iomem_addr`  in  32: byte address; bits [7:2] select register.
- `iomem_wstrb`  in  4: byte write strobes; all zero means read.
- `iomem_wdata`  in  32: write data.
- `iomem_rdata`  out  32: read data, registered, valid while `iomem_ready`=1.
- `irq_out`  out  1: level interrupt to CPU `irq[n]`, registered.

## Operation
Registers (offset from BASE_ADDR):
- 0x00 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable); other bits read 0; written via `wstrb[0]`.
- 0x04 LOAD: 32-bit reload value; per-byte strobes.
- 0x08 COUNT: current counter value. A write loads COUNT directly (per-byte strobes).
- 0x0C STATUS: bit0 EXP, sticky; writing 1 with `wstrb[0]` clears it, writing 0 has no effect.
- Other offsets in the window: read 0, writes ignored, still acknowledged.

Counter, per tick (every clock when EN=1):
- COUNT != 0: COUNT <= COUNT - 1.
- COUNT == 0: set EXP. If AUTO=1, COUNT <= LOAD. If AUTO=0, clear EN and hold COUNT at 0.
- EN=0: COUNT holds.
- LOAD=0 with AUTO=1: EXP sets on every tick.
- Arithmetic is modulo 2^32, but underflow never occurs because the 0 case is handled explicitly.

`irq_out` is registered from `EXP & IE` and stays high until software clears EXP or IE.

Priorities within the same cycle:
- Bus write to COUNT beats decrement and reload.
- Bus write to CTRL.EN beats the hardware clear of EN on one-shot expiry.
- Hardware set of EXP beats a W1C clear.

## Timing
- Reset values: `iomem_ready`=0, `iomem_rdata`=0, `irq_out`=0, CTRL=0, LOAD=0, COUNT=0, EXP=0, prescaler=0.
- Bus handshake: a request is accepted in the cycle `iomem_valid`=1, the address is in the window, and `iomem_ready`=0.
  - In that cycle the write is applied at the clock edge, and `iomem_ready`/`iomem_rdata` are registered.
  - `iomem_ready` is high for exactly one cycle, so latency is 1 cycle.
  - The next cycle `ready` is forced low, even if `valid` persists, to prevent double accept.
- Read of COUNT returns the value before that edge's update.
- Expiry timing: COUNT reaching 0 at edge N sets EXP at edge N+1 and raises `irq_out` at edge N+2.
- Reset asserted mid-transfer or mid-count: everything returns to reset values immediately; no pending ack survives.

## Configuration
`ATTOSOC_TIMER_PRESCALER_EN`
- Defined:
  - Adds PRESCALE register at 0x10 (16 bits, per-byte strobes) and a 16-bit prescaler counter.
  - A tick occurs when the prescaler counter reaches PRESCALE, after which the prescaler counter returns to 0. The tick period is PRESCALE+1 clocks.
  - Writing CTRL.EN from 0 to 1 zeroes the prescaler counter.
- Undefined: no prescaler logic; every clock with EN=1 is a tick; offset 0x10 reads 0.

## Test plan
- Reset: hold `resetn`=0 with random bus activity, then release → all registers read 0, `irq_out`=0, and each read gives exactly one `iomem_ready` pulse per request.
- One-shot: write COUNT=5, then CTRL=0x5 → COUNT reads decreasing values; EXP=1 and `irq_out`=1 two cycles after COUNT hits 0; CTRL reads 0x4; COUNT stays 0.
- Auto-reload: LOAD=3, COUNT=3, CTRL=0x7 → `irq_out` stays asserted; clearing EXP each time gives an EXP set every 4 ticks; COUNT cycles 3,2,1,0,3.
- Collision: issue a W1C of STATUS in the same cycle EXP is set → EXP reads 1 afterwards. Write COUNT=100 in the expiry cycle → COUNT=100, no reload.
- Byte strobes: write LOAD=0xAABBCCDD, then write 0x11223344 with `wstrb`=4'b0010 → LOAD reads 0xAABB33DD. Unmapped offset 0x20 → reads 0, acknowledged.
- With `ATTOSOC_TIMER_PRESCALER_EN`: PRESCALE=2, COUNT=2, EN=1 → COUNT decrements every 3 clocks; EXP sets 9 clocks after enable, ±1 per the timing rules.

Source files
------------

// File: rtl/attosoc_timer.sv
// attosoc_timer: memory-mapped 32-bit down-counting timer with a level IRQ for the PicoRV32 iomem bus.
// Latency: 1 cycle from an accepted request to the iomem_ready pulse; irq_out is registered from EXP & IE.
// Backpressure: none; the cycle after an ack, ready is forced low, so a held iomem_valid re-accepts only every other cycle.
// Optional feature: define ATTOSOC_TIMER_PRESCALER_EN to add a 16-bit PRESCALE register at offset 0x10.
module attosoc_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [31:0] iomem_addr,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq_out
);

  // Register state
  logic        en;
  logic        auto_rl;
  logic        ie;
  logic        exp_flag;
  logic [31:0] load_val;
  logic [31:0] count;

  // Bus decode
  logic       sel;
  logic       acc;
  logic       wr;
  logic [5:0] reg_idx;
  logic       wr_ctrl;
  logic       wr_load;
  logic       wr_count;
  logic       wr_status;
  logic       tick;
  logic       expire;
  logic [31:0] rd_val;

  // Address bits [1:0] are don't-care: registers are word-aligned.
  logic unused_addr;
  assign unused_addr = ^iomem_addr[1:0];

  assign sel       = (iomem_addr[31:8] == BASE_ADDR[31:8]);
  // Ready doubles as a guard: never accept in the cycle an ack is already out.
  assign acc       = iomem_valid && sel && !iomem_ready;
  assign wr        = acc && (iomem_wstrb != 4'b0000);
  assign reg_idx   = iomem_addr[7:2];
  assign wr_ctrl   = wr && (reg_idx == 6'd0) && iomem_wstrb[0];
  assign wr_load   = wr && (reg_idx == 6'd1);
  assign wr_count  = wr && (reg_idx == 6'd2);
  assign wr_status = wr && (reg_idx == 6'd3) && iomem_wstrb[0] && iomem_wdata[0];

  // Byte-lane merge of a write into a 32-bit register.
  function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

`ifdef ATTOSOC_TIMER_PRESCALER_EN
  logic [15:0] prescale;
  logic [15:0] presc_cnt;
  logic        wr_presc;

  assign wr_presc = wr && (reg_idx == 6'd4);
  // ">=" rather than "==" so lowering PRESCALE below the running count
  // produces a tick right away instead of a 64k-clock wrap.
  assign tick     = en && (presc_cnt >= prescale);

  // PRESCALE register, byte-writable on its two low lanes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prescale <= 16'h0000;
    end else if (wr_presc) begin
      if (iomem_wstrb[0]) prescale[7:0]  <= iomem_wdata[7:0];
      if (iomem_wstrb[1]) prescale[15:8] <= iomem_wdata[15:8];
    end
  end

  // Prescaler counter: restarts on an EN rising write, wraps to 0 on each tick
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_cnt <= 16'h0000;
    end else if (wr_ctrl && iomem_wdata[0] && !en) begin
      presc_cnt <= 16'h0000;
    end else if (en) begin
      if (tick) presc_cnt <= 16'h0000;
      else      presc_cnt <= presc_cnt + 16'd1;
    end
  end
`else
  assign tick = en;
`endif

  assign expire = tick && (count == 32'h0000_0000);

  // Read mux; unmapped offsets read as zero
  always_comb begin
    rd_val = 32'h0000_0000;
    case (reg_idx)
      6'd0: rd_val = {29'h0, ie, auto_rl, en};
      6'd1: rd_val = load_val;
      6'd2: rd_val = count;
      6'd3: rd_val = {31'h0, exp_flag};
`ifdef ATTOSOC_TIMER_PRESCALER_EN
      6'd4: rd_val = {16'h0, prescale};
`endif
      default: rd_val = 32'h0000_0000;
    endcase
  end

  // Bus response: one-cycle ack with the pre-update register value
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'h0000_0000;
    end else begin
      iomem_ready <= acc;
      iomem_rdata <= acc ? rd_val : 32'h0000_0000;
    end
  end

  // CTRL: a software write wins over the one-shot hardware clear of EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
    end else if (wr_ctrl) begin
      en      <= iomem_wdata[0];
      auto_rl <= iomem_wdata[1];
      ie      <= iomem_wdata[2];
    end else if (expire && !auto_rl) begin
      en <= 1'b0;
    end
  end

  // LOAD register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      load_val <= 32'h0000_0000;
    end else if (wr_load) begin
      load_val <= merge32(load_val, iomem_wdata, iomem_wstrb);
    end
  end

  // COUNT: bus write beats decrement/reload; a one-shot parks at zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 32'h0000_0000;
    end else if (wr_count) begin
      count <= merge32(count, iomem_wdata, iomem_wstrb);
    end else if (tick) begin
      if (count != 32'h0000_0000) count <= count - 32'd1;
      else if (auto_rl)           count <= load_val;
    end
  end

  // EXP: sticky; a hardware set beats a same-cycle W1C
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_flag <= 1'b0;
    end else if (expire) begin
      exp_flag <= 1'b1;
    end else if (wr_status) begin
      exp_flag <= 1'b0;
    end
  end

  // Interrupt line, registered so it lands one cycle after EXP
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq_out <= 1'b0;
    else         irq_out <= exp_flag & ie;
  end

endmodule

// File: tb/tb_attosoc_timer.sv
// Directed bench for attosoc_timer: bus tasks drive on the falling edge and sample 1 ns after the rising edge.
// Back-to-back bus calls are accepted exactly two clocks apart (the ack cycle blocks a re-accept);
// expected values below are derived from that spacing, with "A" the accept edge of the CTRL write.
module tb_attosoc_timer;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [31:0] iomem_addr = 32'h0;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic        irq_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  attosoc_timer #(.BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_addr  (iomem_addr),
    .iomem_wstrb (iomem_wstrb),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .irq_out     (irq_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic bus(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] data,
                     output logic [31:0] rd, output logic acked);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = BASE | {24'h0, off};
    iomem_wstrb = strb;
    iomem_wdata = data;
    acked = 1'b0;
    rd    = 32'h0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk); #1;
      if (iomem_ready) begin
        acked = 1'b1;
        rd    = iomem_rdata;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic wr(input string tag, input logic [7:0] off, input logic [3:0] strb, input logic [31:0] data);
    logic [31:0] r;
    logic a;
    bus(off, strb, data, r, a);
    check({tag, "_ack"}, {31'h0, a}, 32'h1);
  endtask

  task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] r;
    logic a;
    bus(off, 4'h0, 32'h0, r, a);
    check({tag, "_ack"}, {31'h0, a}, 32'h1);
    check(tag, r, exp);
  endtask

  initial begin
    logic bad;
    logic [3:0] pat;
    int rcount;

    // Reset held with random bus traffic: outputs must stay quiet
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iomem_valid = 1'($urandom_range(0, 1));
      iomem_addr  = BASE | {24'h0, 8'($urandom_range(0, 63)) & 8'hFC};
      iomem_wstrb = 4'($urandom_range(0, 15));
      iomem_wdata = $urandom;
      @(posedge clk); #1;
      if (iomem_ready || irq_out || (iomem_rdata != 32'h0)) bad = 1'b1;
    end
    check("reset_quiet", {31'h0, bad}, 32'h0);
    @(negedge clk);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    resetn = 1'b1;

    rd("rst_ctrl",   8'h00, 32'h0);
    rd("rst_load",   8'h04, 32'h0);
    rd("rst_count",  8'h08, 32'h0);
    rd("rst_status", 8'h0C, 32'h0);
    check("rst_irq", {31'h0, irq_out}, 32'h0);

    // Free-running decrement, then hold once EN drops
    wr("dec_count", 8'h08, 4'hF, 32'd20);
    wr("dec_ctrl",  8'h00, 4'hF, 32'h1);          // A
    rd("dec_rd1",   8'h08, 32'd19);               // A+2
    rd("dec_rd2",   8'h08, 32'd17);               // A+4
    wr("dec_stop",  8'h00, 4'hF, 32'h0);          // A+6, last tick here -> 14
    rd("dec_hold",  8'h08, 32'd14);               // A+8

    // One-shot with IE: COUNT hits 0 at A+5, EXP at A+6, irq at A+7
    wr("os_count", 8'h08, 4'hF, 32'd5);
    wr("os_ctrl",  8'h00, 4'hF, 32'h5);           // A
    repeat (6) @(posedge clk);
    #1 check("os_irq_early", {31'h0, irq_out}, 32'h0);
    @(posedge clk);
    #1 check("os_irq_set", {31'h0, irq_out}, 32'h1);
    rd("os_status", 8'h0C, 32'h1);
    rd("os_ctrl_rd", 8'h00, 32'h4);
    rd("os_count_rd", 8'h08, 32'h0);
    wr("os_w1c", 8'h0C, 4'h1, 32'h1);
    rd("os_status_clr", 8'h0C, 32'h0);
    check("os_irq_clr", {31'h0, irq_out}, 32'h0);
    wr("os_off", 8'h00, 4'hF, 32'h0);

    // Auto-reload LOAD=3: expiries at A+4, A+8, A+12, A+16 ...
    wr("ar_load",  8'h04, 4'hF, 32'd3);
    wr("ar_count", 8'h08, 4'hF, 32'd3);
    wr("ar_ctrl",  8'h00, 4'hF, 32'h7);           // A
    rd("ar_c1", 8'h08, 32'd2);                    // A+2
    rd("ar_c2", 8'h08, 32'd0);                    // A+4
    rd("ar_c3", 8'h08, 32'd2);                    // A+6
    rd("ar_c4", 8'h08, 32'd0);                    // A+8
    check("ar_irq", {31'h0, irq_out}, 32'h1);
    wr("ar_w1c", 8'h0C, 4'h1, 32'h1);             // A+10, no expiry
    rd("ar_st_clr", 8'h0C, 32'h0);                // A+12, pre-update value
    rd("ar_c5", 8'h08, 32'd2);                    // A+14
    wr("ar_w1c_coll", 8'h0C, 4'h1, 32'h1);        // A+16, collides with expiry
    rd("ar_st_coll", 8'h0C, 32'h1);               // A+18
    check("ar_irq_hold", {31'h0, irq_out}, 32'h1);

    // Asynchronous reset while counting with irq high
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_irq",   {31'h0, irq_out},     32'h0);
    check("mid_rst_ready", {31'h0, iomem_ready}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    rd("mid_rst_ctrl",  8'h00, 32'h0);
    rd("mid_rst_count", 8'h08, 32'h0);
    rd("mid_rst_load",  8'h04, 32'h0);

    // Bus write to COUNT in the expiry cycle beats the reload (LOAD=7)
    wr("cw_load",  8'h04, 4'hF, 32'd7);
    wr("cw_count", 8'h08, 4'hF, 32'd3);
    wr("cw_ctrl",  8'h00, 4'hF, 32'h3);           // A, expiry at A+4
    rd("cw_load_rd", 8'h04, 32'd7);               // A+2
    wr("cw_wr100", 8'h08, 4'hF, 32'd100);         // A+4
    rd("cw_count_rd", 8'h08, 32'd99);             // A+6: 100 then one tick
    rd("cw_status", 8'h0C, 32'h1);                // A+8
    wr("cw_stop", 8'h00, 4'hF, 32'h0);
    wr("cw_w1c", 8'h0C, 4'h1, 32'h1);
    rd("cw_status_clr", 8'h0C, 32'h0);

    // Byte strobes and CTRL field masking
    wr("bs_load_full", 8'h04, 4'hF, 32'hAABB_CCDD);
    wr("bs_load_b1",   8'h04, 4'b0010, 32'h1122_3344);
    rd("bs_load_rd",   8'h04, 32'hAABB_33DD);
    wr("bs_count_z",   8'h08, 4'hF, 32'h0);
    wr("bs_count_b2",  8'h08, 4'b0100, 32'h1177_2233);
    rd("bs_count_rd",  8'h08, 32'h0077_0000);
    wr("bs_ctrl",      8'h00, 4'hF, 32'hFFFF_FFF6);
    rd("bs_ctrl_rd",   8'h00, 32'h6);
    wr("bs_ctrl_nob0", 8'h00, 4'b0010, 32'h0000_0001);
    rd("bs_ctrl_keep", 8'h00, 32'h6);
    wr("bs_ctrl_off",  8'h00, 4'hF, 32'h0);

    // Unmapped in-window offset: acknowledged, reads 0
    wr("unm_wr", 8'h20, 4'hF, 32'hDEAD_BEEF);
    rd("unm_rd", 8'h20, 32'h0);

    // Outside the window: never acknowledged
    @(negedge clk);
    iomem_addr  = 32'h0400_0008;
    iomem_wstrb = 4'h0;
    iomem_valid = 1'b1;
    rcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (iomem_ready) rcount++;
    end
    iomem_valid = 1'b0;
    check("out_of_window", rcount, 32'h0);

    // Held valid: ready pulses one cycle, then is forced low
    @(negedge clk);
    iomem_addr  = BASE;
    iomem_valid = 1'b1;
    pat = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat = {pat[2:0], iomem_ready};
    end
    iomem_valid = 1'b0;
    check("held_valid_pattern", {28'h0, pat}, 32'hA);

`ifdef ATTOSOC_TIMER_PRESCALER_EN
    // PRESCALE=2: ticks at A+3, A+6, A+9; EXP set at A+9
    wr("ps_prescale", 8'h10, 4'b0011, 32'd2);
    rd("ps_prescale_rd", 8'h10, 32'd2);
    wr("ps_count", 8'h08, 4'hF, 32'd2);
    wr("ps_ctrl",  8'h00, 4'hF, 32'h1);           // A
    rd("ps_c1", 8'h08, 32'd2);                    // A+2
    rd("ps_c2", 8'h08, 32'd1);                    // A+4
    rd("ps_c3", 8'h08, 32'd1);                    // A+6, pre-update
    rd("ps_st0", 8'h0C, 32'h0);                   // A+8
    rd("ps_st1", 8'h0C, 32'h1);                   // A+10
`else
    // Offset 0x10 is unmapped without the prescaler
    wr("ps_absent_wr", 8'h10, 4'hF, 32'd5);
    rd("ps_absent_rd", 8'h10, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
